// File: rtl/brch_resolve_recover_pkg.sv
// Shared types and constants for the branch resolution / recovery unit.
package brch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BR_ID = 2'd1,
    FLUSH = 2'd2
  } brch_st_e;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/brch_resolve_recover_if.sv
// Pipeline-side bundle of the branch resolution unit: master is the pipeline, slave is the unit.
interface brch_resolve_recover_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);

  logic             brch_instr_detectd_IF;
  logic             prediction;
  logic [PC_W-1:0]  pc_IF;
  logic             brch_hazard_stall;
  logic             actual_brch_result;
  logic [PC_W-1:0]  brch_target_ID;
  logic             brch_instr_detectd_ID;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_IF;
  logic             flush_ID;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output brch_instr_detectd_IF, prediction, pc_IF, brch_hazard_stall,
           actual_brch_result, brch_target_ID,
    input  brch_instr_detectd_ID, redirect_valid, redirect_pc, flush_IF,
           flush_ID, branch_cnt, mispred_cnt
  );

  modport slave (
    input  brch_instr_detectd_IF, prediction, pc_IF, brch_hazard_stall,
           actual_brch_result, brch_target_ID,
    output brch_instr_detectd_ID, redirect_valid, redirect_pc, flush_IF,
           flush_ID, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/brch_resolve_recover_sat_counter.sv
// Registered up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: step only while below the ceiling.
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      value_d = value_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= {CNT_W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/brch_resolve_recover.sv
// Carries the IF prediction to ID, resolves it there and issues a one-cycle redirect/flush on mismatch.
module brch_resolve_recover #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  brch_resolve_recover_if.slave  bus
);

  import brch_pkg::*;

  brch_st_e        state_q, state_d;
  logic            slot_vld_q, slot_vld_d;
  logic            slot_pred_q, slot_pred_d;
  logic [PC_W-1:0] slot_pc_q, slot_pc_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            flush_if_q, flush_if_d;
  logic            flush_id_q, flush_id_d;

  logic            resolve_s;
  logic            mismatch_s;
  logic            capture_s;

  // A capture is only legal when the slot is free now or is freed by a correct resolve.
  assign resolve_s  = (state_q == BR_ID) && !bus.brch_hazard_stall;
  assign mismatch_s = resolve_s && (bus.actual_brch_result != slot_pred_q);
  assign capture_s  = bus.brch_instr_detectd_IF &&
                      ((state_q == IDLE) || (resolve_s && !mismatch_s));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_s) state_d = BR_ID;
        else           state_d = IDLE;
      end
      BR_ID: begin
        if (bus.brch_hazard_stall) state_d = BR_ID;
        else if (mismatch_s)       state_d = FLUSH;
        else if (capture_s)        state_d = BR_ID;
        else                       state_d = IDLE;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; redirect and flushes go high the cycle after a mismatch.
  always_comb begin
    slot_vld_d       = slot_vld_q;
    slot_pred_d      = slot_pred_q;
    slot_pc_d        = slot_pc_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = mismatch_s;
    flush_if_d       = mismatch_s;
    flush_id_d       = mismatch_s;

    if (capture_s) begin
      slot_vld_d  = 1'b1;
      slot_pred_d = bus.prediction;
      slot_pc_d   = bus.pc_IF;
    end else if (resolve_s) begin
      slot_vld_d  = 1'b0;
    end else begin
      slot_vld_d  = slot_vld_q;
    end

    if (mismatch_s) begin
      if (bus.actual_brch_result) redirect_pc_d = bus.brch_target_ID;
      else                        redirect_pc_d = slot_pc_q + PC_W'(PC_INCR);
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // Slot and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld_q       <= 1'b0;
      slot_pred_q      <= 1'b0;
      slot_pc_q        <= {PC_W{1'b0}};
      redirect_pc_q    <= {PC_W{1'b0}};
      redirect_valid_q <= 1'b0;
      flush_if_q       <= 1'b0;
      flush_id_q       <= 1'b0;
    end else begin
      slot_vld_q       <= slot_vld_d;
      slot_pred_q      <= slot_pred_d;
      slot_pc_q        <= slot_pc_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      flush_if_q       <= flush_if_d;
      flush_id_q       <= flush_id_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve_s),
    .value (bus.branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mismatch_s),
    .value (bus.mispred_cnt)
  );

  assign bus.brch_instr_detectd_ID = slot_vld_q;
  assign bus.redirect_valid        = redirect_valid_q;
  assign bus.redirect_pc           = redirect_pc_q;
  assign bus.flush_IF              = flush_if_q;
  assign bus.flush_ID              = flush_id_q;

endmodule

// File: tb/tb_brch_resolve_recover.sv
// Directed bench: a 16-bit-counter unit and a 2-bit-counter unit share the same stimulus.
module tb_brch_resolve_recover;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  brch_resolve_recover_if #(.PC_W(32), .CNT_W(16)) bus ();
  brch_resolve_recover_if #(.PC_W(32), .CNT_W(2))  bus_s ();

  brch_resolve_recover #(.PC_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  brch_resolve_recover #(.PC_W(32), .CNT_W(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  assign bus_s.brch_instr_detectd_IF = bus.brch_instr_detectd_IF;
  assign bus_s.prediction            = bus.prediction;
  assign bus_s.pc_IF                 = bus.pc_IF;
  assign bus_s.brch_hazard_stall     = bus.brch_hazard_stall;
  assign bus_s.actual_brch_result    = bus.actual_brch_result;
  assign bus_s.brch_target_ID        = bus.brch_target_ID;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic br, input logic pred, input logic [31:0] pc,
                       input logic stall, input logic act, input logic [31:0] tgt);
    bus.brch_instr_detectd_IF = br;
    bus.prediction            = pred;
    bus.pc_IF                 = pc;
    bus.brch_hazard_stall     = stall;
    bus.actual_brch_result    = act;
    bus.brch_target_ID        = tgt;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    chk("rst_slot",   bus.brch_instr_detectd_ID, 64'd0);
    chk("rst_rv",     bus.redirect_valid,        64'd0);
    chk("rst_rpc",    bus.redirect_pc,           64'h0);
    chk("rst_fif",    bus.flush_IF,              64'd0);
    chk("rst_fid",    bus.flush_ID,              64'd0);
    chk("rst_bcnt",   bus.branch_cnt,            64'd0);
    chk("rst_mcnt",   bus.mispred_cnt,           64'd0);
    rst_n = 1'b1;

    // Correct prediction, not taken.
    drive(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    chk("cp_slot",    bus.brch_instr_detectd_ID, 64'd1);
    chk("cp_bcnt0",   bus.branch_cnt,            64'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("cp_rv",      bus.redirect_valid,        64'd0);
    chk("cp_bcnt",    bus.branch_cnt,            64'd1);
    chk("cp_mcnt",    bus.mispred_cnt,           64'd0);
    chk("cp_empty",   bus.brch_instr_detectd_ID, 64'd0);

    // Predicted not-taken, actually taken.
    drive(1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h240);
    tick();
    chk("mnt_rv",     bus.redirect_valid,        64'd1);
    chk("mnt_rpc",    bus.redirect_pc,           64'h240);
    chk("mnt_fif",    bus.flush_IF,              64'd1);
    chk("mnt_fid",    bus.flush_ID,              64'd1);
    chk("mnt_mcnt",   bus.mispred_cnt,           64'd1);
    chk("mnt_bcnt",   bus.branch_cnt,            64'd2);
    chk("mnt_slot",   bus.brch_instr_detectd_ID, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mnt_rv_lo",  bus.redirect_valid,        64'd0);
    chk("mnt_fif_lo", bus.flush_IF,              64'd0);
    chk("mnt_fid_lo", bus.flush_ID,              64'd0);

    // Predicted taken, actually not taken; IF branches on the wrong path are dropped.
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 32'h999);
    tick();
    chk("mt_rv",      bus.redirect_valid,        64'd1);
    chk("mt_rpc",     bus.redirect_pc,           64'h304);
    chk("mt_slot",    bus.brch_instr_detectd_ID, 64'd0);
    chk("mt_mcnt",    bus.mispred_cnt,           64'd2);
    chk("mt_bcnt",    bus.branch_cnt,            64'd3);
    drive(1'b1, 1'b0, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mt_fl_slot", bus.brch_instr_detectd_ID, 64'd0);
    chk("mt_rv_lo",   bus.redirect_valid,        64'd0);

    // Hazard stall for three cycles, with an IF branch waiting behind it.
    drive(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0);
      tick();
      chk("st_slot",  bus.brch_instr_detectd_ID, 64'd1);
      chk("st_bcnt",  bus.branch_cnt,            64'd3);
      chk("st_mcnt",  bus.mispred_cnt,           64'd2);
      chk("st_rv",    bus.redirect_valid,        64'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("st_res_bcnt", bus.branch_cnt,           64'd4);
    chk("st_res_mcnt", bus.mispred_cnt,          64'd2);
    chk("st_res_rv",   bus.redirect_valid,       64'd0);
    chk("st_res_slot", bus.brch_instr_detectd_ID, 64'd0);

    // Back-to-back correct branches.
    drive(1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bb_slot1",   bus.brch_instr_detectd_ID, 64'd1);
    drive(1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bb_slot2",   bus.brch_instr_detectd_ID, 64'd1);
    chk("bb_bcnt1",   bus.branch_cnt,            64'd5);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("bb_slot3",   bus.brch_instr_detectd_ID, 64'd0);
    chk("bb_bcnt2",   bus.branch_cnt,            64'd6);
    chk("bb_mcnt",    bus.mispred_cnt,           64'd2);
    chk("bb_rv",      bus.redirect_valid,        64'd0);

    // Fall-through address wraps around the top of the PC space.
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wr_rpc",     bus.redirect_pc,           64'h3);
    chk("wr_mcnt",    bus.mispred_cnt,           64'd3);
    tick();

    // Reset during the redirect cycle.
    drive(1'b1, 1'b0, 32'h900, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h940);
    tick();
    chk("rf_rv_hi",   bus.redirect_valid,        64'd1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rf_rv",      bus.redirect_valid,        64'd0);
    chk("rf_fif",     bus.flush_IF,              64'd0);
    chk("rf_bcnt",    bus.branch_cnt,            64'd0);
    chk("rf_mcnt",    bus.mispred_cnt,           64'd0);
    chk("rf_rpc",     bus.redirect_pc,           64'h0);
    rst_n = 1'b1;

    // Five mispredicts: the 2-bit counters stop at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h1000 + 32'(i * 16), 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk("sat_mcnt16", bus.mispred_cnt,           64'd5);
    chk("sat_bcnt16", bus.branch_cnt,            64'd5);
    chk("sat_mcnt2",  bus_s.mispred_cnt,         64'd3);
    chk("sat_bcnt2",  bus_s.branch_cnt,          64'd3);
    chk("sat_rpc2",   bus_s.redirect_pc,         64'h2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
